// File: rtl/ifq_pkg.sv
// ifq_pkg: shared constants and types for the instruction fetch queue.
//   IFQ_RESET_PC : default first fetch address after reset
//   INSTR_W      : instruction word width
//   ifq_entry_t  : one buffered fetch, instruction word plus its PC
package ifq_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous DEPTH-entry FIFO of {instr, pc} entries.
//   clk        : clock, all state on rising edge
//   reset      : synchronous active-low reset
//   push       : write push_instr/push_pc at the tail (never issued when full)
//   pop        : remove the head entry (ignored when empty)
//   flush      : discard every entry; wins over push and pop
//   head_instr : instruction at the head (meaningful only when count != 0)
//   head_pc    : PC at the head (meaningful only when count != 0)
//   count      : number of buffered entries, 0..DEPTH
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [INSTR_W-1:0]     push_instr,
    input  logic [31:0]            push_pc,
    input  logic                   pop,
    input  logic                   flush,
    output logic [INSTR_W-1:0]     head_instr,
    output logic [31:0]            head_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ifq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    assign do_pop = pop && (count != '0);

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; count and the pointers alone say
    // which slots hold live data, so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{instr: push_instr, pc: push_pc};
        end
    end

    assign head_instr = mem[rd_ptr].instr;
    assign head_pc    = mem[rd_ptr].pc;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue in front of decode. Owns the fetch PC,
// issues word reads to an in-order variable-latency instruction memory,
// buffers returned words with their PCs and flushes on redirect.
//   clk            : clock, all state on rising edge
//   reset          : synchronous active-low reset
//   imem_req_valid : fetch request valid
//   imem_req_ready : memory accepts the request this cycle
//   imem_req_addr  : word-aligned fetch address
//   imem_rsp_valid : response valid (in order, no backpressure)
//   imem_rsp_data  : returned instruction word
//   redirect       : taken branch/jump/jr this cycle
//   redirect_pc    : new fetch target, low two bits forced to zero
//   out_valid      : queue head valid
//   out_ready      : decode accepts the head
//   out_instr      : head instruction, 0 when out_valid is low
//   out_pc         : head PC, 0 when out_valid is low
//   out_pc4        : head PC + 4, 0 when out_valid is low
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc4
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_V = DEPTH[CNT_W:0];

    logic [31:0]        fetch_pc;
    logic [31:0]        rsp_pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W:0]     in_use;
    logic [31:0]        target;
    logic [INSTR_W-1:0] head_instr;
    logic [31:0]        head_pc;
    logic               req_fire;
    logic               rsp_take;
    logic               rsp_keep;
    logic               pop;

    // Every buffered entry and every in-flight fetch holds a slot, so the
    // queue can never be asked to take a response it has no room for.
    assign in_use         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = reset && !redirect && (in_use < DEPTH_V);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are leftovers from before a reset.
    assign rsp_take = imem_rsp_valid && (outstanding != '0);
    // A response in the redirect cycle belongs to the abandoned stream.
    assign rsp_keep = rsp_take && (drop_cnt == '0) && !redirect;
    assign pop      = out_valid && out_ready;
    assign target   = {redirect_pc[31:2], 2'b00};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            // No request can fire this cycle, so everything still in flight
            // after any retiring response is old-stream and must be dropped.
            fetch_pc    <= target;
            rsp_pc      <= target;
            outstanding <= outstanding - CNT_W'(rsp_take);
            drop_cnt    <= outstanding - CNT_W'(rsp_take);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (rsp_keep),
        .push_instr (imem_rsp_data),
        .push_pc    (rsp_pc),
        .pop        (pop),
        .flush      (redirect),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (count)
    );

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head_instr       : '0;
    assign out_pc    = out_valid ? head_pc          : '0;
    assign out_pc4   = out_valid ? head_pc + 32'd4  : '0;

endmodule
